// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debugger command path:
// opcodes, error codes and parser states.
package uart_dbg_pkg;

  localparam logic [7:0] OPC_READ  = 8'h52;
  localparam logic [7:0] OPC_WRITE = 8'h57;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OPCODE  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ISSUE = 2'd3
  } parser_state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OPC_READ) || (b == OPC_WRITE);
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle timer: counts cycles since the last accepted byte while
// enabled and flags expiry once TIMEOUT_CYCLES full cycles have elapsed.
module uart_byte_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;

  // Saturates at LIMIT; the parser leaves the frame states on expiry anyway.
  always_ff @(posedge clk) begin
    if (rst || i_clear || !i_enable) begin
      r_count <= '0;
    end else if (r_count != LIMIT) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles framed read/write commands from UART receiver byte strobes and
// hands them to the debug bus master over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an opcode byte
// ADDR  | shifting in address bytes, MSB first
// DATA  | shifting in write-data bytes, MSB first
// ISSUE | command presented on cmd_*, waiting for cmd_ready_i
module uart_cmd_parser
  import uart_dbg_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              cmd_write_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [DATA_W-1:0] cmd_wdata_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BCNT_W     = $clog2(MAX_BYTES + 1);
  localparam logic [BCNT_W-1:0] LAST_ADDR = BCNT_W'(ADDR_BYTES - 1);
  localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(DATA_BYTES - 1);

  parser_state_t     r_state;
  logic [BCNT_W-1:0] r_byte_cnt;
  logic              r_valid;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  err_code_t         r_err_code;

  logic w_in_frame;
  logic w_handshake;
  logic w_take_opc;
  logic w_expired;

  assign w_in_frame  = (r_state == ADDR) || (r_state == DATA);
  assign w_handshake = r_valid && cmd_ready_i;
  // A byte landing on the handshake cycle is treated as the next opcode.
  assign w_take_opc  = rx_valid_i && ((r_state == IDLE) || w_handshake);

  uart_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_in_frame && rx_valid_i),
    .i_enable (w_in_frame),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_valid    <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ADDR: begin
          if (rx_valid_i) begin
            r_addr <= (r_addr << 8) | ADDR_W'(rx_data_i);
            if (r_byte_cnt == LAST_ADDR) begin
              r_byte_cnt <= '0;
              if (r_write) begin
                r_state <= DATA;
              end else begin
                r_state <= ISSUE;
                r_valid <= 1'b1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end else if (w_expired) begin
            r_state    <= IDLE;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end
        end
        DATA: begin
          if (rx_valid_i) begin
            r_wdata <= (r_wdata << 8) | DATA_W'(rx_data_i);
            if (r_byte_cnt == LAST_DATA) begin
              r_byte_cnt <= '0;
              r_state    <= ISSUE;
              r_valid    <= 1'b1;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end else if (w_expired) begin
            r_state    <= IDLE;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end
        end
        ISSUE: begin
          if (w_handshake) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else if (rx_valid_i) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_OVERRUN;
          end
        end
        default: ;
      endcase

      if (w_take_opc) begin
        if (is_opcode(rx_data_i)) begin
          r_write    <= (rx_data_i == OPC_WRITE);
          r_addr     <= '0;
          r_wdata    <= '0;
          r_byte_cnt <= '0;
          r_state    <= ADDR;
        end else begin
          r_err      <= 1'b1;
          r_err_code <= ERR_OPCODE;
        end
      end
    end
  end

  assign cmd_valid_o = r_valid;
  assign cmd_write_o = r_write;
  assign cmd_addr_o  = r_addr;
  assign cmd_wdata_o = r_wdata;
  assign err_o       = r_err;
  assign err_code_o  = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected commands and
// error codes, a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_cmd_parser;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int T      = 20;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } cmd_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data_i = 8'h00;
  logic              rx_valid_i = 1'b0;
  logic              cmd_valid_o;
  logic              cmd_ready_i = 1'b0;
  logic              cmd_write_o;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic [DATA_W-1:0] cmd_wdata_o;
  logic              err_o;
  logic [1:0]        err_code_o;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   err_cyc = 0;
  int   strobe_cyc = 0;
  logic err_seen = 1'b0;

  cmd_t       cmd_q[$];
  logic [1:0] err_q[$];

  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  cmd_t prev_cmd;

  uart_cmd_parser #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_write_o(cmd_write_o), .cmd_addr_o(cmd_addr_o), .cmd_wdata_o(cmd_wdata_o),
    .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(cmd_valid_o), 64'd0);
    chk({tag, "_write"}, 64'(cmd_write_o), 64'd0);
    chk({tag, "_addr"},  64'(cmd_addr_o),  64'd0);
    chk({tag, "_wdata"}, 64'(cmd_wdata_o), 64'd0);
    chk({tag, "_err"},   64'(err_o),       64'd0);
    chk({tag, "_code"},  64'(err_code_o),  64'd0);
  endtask

  // Monitor: command stability, handshake scoreboard, error scoreboard.
  always @(negedge clk) begin
    cmd_t act;
    cmd_t e;
    logic [1:0] ec;
    act = '{w: cmd_write_o, a: cmd_addr_o, d: cmd_wdata_o};
    if (!rst) begin
      if (cmd_valid_o && prev_valid && !prev_hs) begin
        vectors++;
        if (act !== prev_cmd) begin
          miscompares++;
          $display("FAIL cmd_stable: got %h expected %h", act, prev_cmd);
        end
      end
      if (cmd_valid_o && cmd_ready_i) begin
        vectors++;
        if (cmd_q.size() == 0) begin
          miscompares++;
          $display("FAIL cmd_unexpected: got %h expected none", act);
        end else begin
          e = cmd_q.pop_front();
          if (act !== e) begin
            miscompares++;
            $display("FAIL cmd: got %h expected %h", act, e);
          end
        end
      end
      if (err_o) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
        vectors++;
        if (err_q.size() == 0) begin
          miscompares++;
          $display("FAIL err_unexpected: got code %0d expected no error", err_code_o);
        end else begin
          ec = err_q.pop_front();
          if (err_code_o !== ec) begin
            miscompares++;
            $display("FAIL err_code: got %0d expected %0d", err_code_o, ec);
          end
        end
      end
    end
    prev_valid = cmd_valid_o;
    prev_hs    = cmd_valid_o && cmd_ready_i;
    prev_cmd   = act;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(1);

    // Write frame, ready held high: valid for exactly one cycle after EF.
    cmd_ready_i = 1'b1;
    cmd_q.push_back('{w: 1'b1, a: 16'h0010, d: 32'hDEADBEEF});
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("wr_valid_rise", 64'(cmd_valid_o), 64'd1);
    idle(1);
    chk("wr_valid_fall", 64'(cmd_valid_o), 64'd0);

    // Read frame with ready low 5 cycles: valid held 6 cycles.
    cmd_ready_i = 1'b0;
    cmd_q.push_back('{w: 1'b0, a: 16'h1234, d: 32'h0});
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
    for (int i = 0; i < 5; i++) begin
      chk("rd_valid_hold", 64'(cmd_valid_o), 64'd1);
      idle(1);
    end
    chk("rd_valid_6th", 64'(cmd_valid_o), 64'd1);
    cmd_ready_i = 1'b1;
    idle(1);
    chk("rd_valid_fall", 64'(cmd_valid_o), 64'd0);

    // Bad opcode then a good read.
    err_q.push_back(2'd1);
    send_byte(8'h41);
    cmd_q.push_back('{w: 1'b0, a: 16'hABCD, d: 32'h0});
    send_byte(8'h52); send_byte(8'hAB); send_byte(8'hCD);
    idle(2);
    chk("badopc_code_hold", 64'(err_code_o), 64'd1);

    // Timeout: pulse T+1 cycles after the last accepted byte.
    send_byte(8'h52); send_byte(8'h12);
    strobe_cyc = cyc;
    err_seen = 1'b0;
    err_q.push_back(2'd2);
    for (int i = 0; i < T + 10 && !err_seen; i++) @(posedge clk);
    #1;
    chk("timeout_seen", 64'(err_seen), 64'd1);
    chk("timeout_latency", 64'(err_cyc - strobe_cyc), 64'(T + 1));
    idle(1);
    cmd_q.push_back('{w: 1'b0, a: 16'hABCD, d: 32'h0});
    send_byte(8'h52); send_byte(8'hAB); send_byte(8'hCD);
    idle(2);

    // Overrun while stalled, then opcode byte on the handshake cycle.
    cmd_ready_i = 1'b0;
    cmd_q.push_back('{w: 1'b0, a: 16'h0001, d: 32'h0});
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    err_q.push_back(2'd3);
    send_byte(8'h57);
    chk("ovr_valid", 64'(cmd_valid_o), 64'd1);
    chk("ovr_write", 64'(cmd_write_o), 64'd0);
    chk("ovr_addr",  64'(cmd_addr_o),  64'h0001);
    idle(1);
    cmd_ready_i = 1'b1;
    send_byte(8'h52);
    chk("sim_valid_fall", 64'(cmd_valid_o), 64'd0);
    cmd_q.push_back('{w: 1'b0, a: 16'h0005, d: 32'h0});
    send_byte(8'h00); send_byte(8'h05);
    idle(2);

    // Reset mid-frame discards everything silently.
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'hDE);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_all_zero("midrst");
    cmd_q.push_back('{w: 1'b0, a: 16'h0002, d: 32'h0});
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
    idle(3);

    chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    chk("err_q_drained", 64'(err_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
